// File: rtl/fb_port_arbiter_pkg.sv
// fb_pkg: shared widths, swap-state and owner enums, and the read tag for the framebuffer port-B arbiter.
package fb_pkg;
  localparam int DATA_W = 20;
  localparam int ADDR_W = 16;
  typedef enum logic [1:0] {RUN, WAIT_VS, DRAIN, SWAP} swap_state_e;
  typedef enum logic {OWN_DISP, OWN_ENG} owner_e;
  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;
endpackage

// File: rtl/fb_port_arbiter_if.sv
// fb_port_arbiter_if: display, engine, frame-control and RAM port-B signals of the framebuffer arbiter.
interface fb_port_arbiter_if #(
  parameter int DATA_W = fb_pkg::DATA_W,
  parameter int ADDR_W = fb_pkg::ADDR_W
);
  logic              disp_req, disp_gnt, disp_rvalid;
  logic [ADDR_W-2:0] disp_addr;
  logic [DATA_W-1:0] disp_rdata;
  logic              eng_req, eng_we, eng_gnt, eng_rvalid, eng_done;
  logic [ADDR_W-2:0] eng_addr;
  logic [DATA_W-1:0] eng_wdata, eng_rdata;
  logic              vsync, gen_start, front_bank;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata, mem_q;
  modport slave (
    input  disp_req, disp_addr, eng_req, eng_we, eng_addr, eng_wdata, eng_done, vsync, mem_q,
    output disp_gnt, disp_rvalid, disp_rdata, eng_gnt, eng_rvalid, eng_rdata, gen_start, front_bank,
           mem_addr, mem_we, mem_wdata
  );
  modport master (
    output disp_req, disp_addr, eng_req, eng_we, eng_addr, eng_wdata, eng_done, vsync, mem_q,
    input  disp_gnt, disp_rvalid, disp_rdata, eng_gnt, eng_rvalid, eng_rdata, gen_start, front_bank,
           mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/fb_port_arbiter_read_tag_pipe.sv
// fb_read_tag_pipe: fixed-depth delay line of read tags with an all-empty flag.
module fb_read_tag_pipe
  import fb_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  tag_t push,
  output tag_t pop,
  output logic empty
);
  tag_t stg [DEPTH];
  always_ff @(posedge clk or posedge reset)
    if (reset) for (int i = 0; i < DEPTH; i++) stg[i] <= '0;
    else begin
      stg[0] <= push;
      for (int i = 1; i < DEPTH; i++) stg[i] <= stg[i-1];
    end
  always_comb begin
    empty = 1'b1;
    for (int i = 0; i < DEPTH; i++) empty = empty && !stg[i].valid;
  end
  assign pop = stg[DEPTH-1];
endmodule

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: port-B arbiter (display priority, engine anti-starvation) with vsync-timed bank swap.
// FB_ARB_PERF_EN adds eng_stall_cnt and frame_repeat_cnt outputs.
module fb_port_arbiter #(
  parameter int DATA_W     = fb_pkg::DATA_W,
  parameter int ADDR_W     = fb_pkg::ADDR_W,
  parameter int READ_LAT   = 2,
  parameter int STARVE_MAX = 64
) (
  input  logic               clk,
  input  logic               reset,
  fb_port_arbiter_if.slave   bus
`ifdef FB_ARB_PERF_EN
  ,
  output logic [31:0]        eng_stall_cnt,
  output logic [15:0]        frame_repeat_cnt
`endif
);
  import fb_pkg::*;
  localparam int SW = $clog2(STARVE_MAX + 1);
  swap_state_e       state;
  logic [SW-1:0]     starve_cnt;
  logic              front_bank, gen_start, mem_we, starved, disp_ok, eng_ok, eng_gnt, disp_gnt, empty;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  tag_t              push, pop;
  always_comb begin
    disp_ok  = !reset && (state == RUN || state == WAIT_VS);
    eng_ok   = !reset && state == RUN;
    starved  = starve_cnt == SW'(STARVE_MAX);
    eng_gnt  = eng_ok && bus.eng_req && (starved || !bus.disp_req);
    disp_gnt = disp_ok && bus.disp_req && !eng_gnt;
    push     = '{valid: disp_gnt || (eng_gnt && !bus.eng_we), owner: disp_gnt ? OWN_DISP : OWN_ENG};
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      starve_cnt <= '0;
      mem_addr   <= '0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      starve_cnt <= eng_gnt ? '0 : (disp_gnt && bus.eng_req && !starved) ? starve_cnt + 1'b1 : starve_cnt;
      mem_we     <= eng_gnt && bus.eng_we;
      if (disp_gnt) mem_addr <= {front_bank, bus.disp_addr};
      else if (eng_gnt) begin
        mem_addr  <= {front_bank ^ bus.eng_we, bus.eng_addr};
        mem_wdata <= bus.eng_wdata;
      end
    end
  // front_bank and gen_start change on the same edge so gen_start marks the new bank's first cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state      <= RUN;
      front_bank <= 1'b0;
      gen_start  <= 1'b0;
    end else begin
      gen_start <= 1'b0;
      case (state)
        RUN:     if (bus.eng_done) state <= WAIT_VS;
        WAIT_VS: if (bus.vsync) state <= DRAIN;
        DRAIN:   if (empty) begin
          state      <= SWAP;
          front_bank <= ~front_bank;
          gen_start  <= 1'b1;
        end
        default: state <= RUN;
      endcase
    end
  fb_read_tag_pipe #(.DEPTH(READ_LAT + 1)) u_tags (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .empty (empty)
  );
  assign bus.disp_gnt    = disp_gnt;
  assign bus.eng_gnt     = eng_gnt;
  assign bus.front_bank  = front_bank;
  assign bus.gen_start   = gen_start;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_we      = mem_we;
  assign bus.mem_wdata   = mem_wdata;
  assign bus.disp_rvalid = pop.valid && pop.owner == OWN_DISP;
  assign bus.eng_rvalid  = pop.valid && pop.owner == OWN_ENG;
  assign bus.disp_rdata  = (pop.valid && pop.owner == OWN_DISP) ? bus.mem_q : '0;
  assign bus.eng_rdata   = (pop.valid && pop.owner == OWN_ENG) ? bus.mem_q : '0;
`ifdef FB_ARB_PERF_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      eng_stall_cnt    <= '0;
      frame_repeat_cnt <= '0;
    end else begin
      eng_stall_cnt    <= eng_stall_cnt + 32'(bus.eng_req && !eng_gnt);
      frame_repeat_cnt <= frame_repeat_cnt + 16'(state == RUN && bus.vsync);
    end
`endif
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: directed self-checking bench for fb_port_arbiter with a 2-cycle-latency RAM model.
module tb_fb_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int failed = 0;
  logic [19:0] r1;
  fb_port_arbiter_if bus ();
`ifdef FB_ARB_PERF_EN
  logic [31:0] eng_stall_cnt;
  logic [15:0] frame_repeat_cnt;
`endif
  fb_port_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef FB_ARB_PERF_EN
    ,
    .eng_stall_cnt    (eng_stall_cnt),
    .frame_repeat_cnt (frame_repeat_cnt)
`endif
  );
  always #5 clk = ~clk;
  function automatic logic [19:0] f(input logic [15:0] a);
    return {a[3:0] ^ 4'h9, a};
  endfunction
  always @(posedge clk) begin
    r1        <= f(bus.mem_addr);
    bus.mem_q <= r1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial begin
    int e_cnt, d_cnt, e_at, bad, erv_n, last_rv, gs_cnt, gs_at, fb_at, rv_n;
    logic [19:0] erd, rd2, rd3;
    bus.disp_req = 1'b1; bus.disp_addr = '0; bus.eng_req = 1'b1; bus.eng_we = 1'b0;
    bus.eng_addr = '0; bus.eng_wdata = '0; bus.eng_done = 1'b0; bus.vsync = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    chk("reset_ctrl", {bus.disp_gnt, bus.eng_gnt, bus.disp_rvalid, bus.eng_rvalid, bus.mem_we, bus.gen_start, bus.front_bank}, 0);
    chk("reset_mem_addr", bus.mem_addr, 0);
    bus.disp_req = 1'b0; bus.eng_req = 1'b0; reset = 1'b0;
    // display read: address at t+1, data at t+3
    @(negedge clk); bus.disp_req = 1'b1; bus.disp_addr = 15'h0010; #1;
    chk("disp_gnt", {bus.disp_gnt, bus.eng_gnt}, 2'b10);
    @(negedge clk); bus.disp_req = 1'b0; #1;
    chk("disp_mem_addr", {bus.mem_we, bus.mem_addr}, {1'b0, 16'h0010});
    @(negedge clk); #1;
    chk("disp_rvalid_early", bus.disp_rvalid, 0);
    @(negedge clk); #1;
    chk("disp_rvalid_t3", {bus.disp_rvalid, bus.eng_rvalid}, 2'b10);
    chk("disp_rdata", bus.disp_rdata, f(16'h0010));
    @(negedge clk); #1;
    chk("disp_rvalid_after", bus.disp_rvalid, 0);
    // starvation: both requesting for 70 cycles
    e_cnt = 0; d_cnt = 0; e_at = 0; bad = 0; erv_n = 0; erd = '0;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      bus.disp_req = 1'b1; bus.disp_addr = 15'(i + 200); bus.eng_req = 1'b1; bus.eng_we = 1'b0; bus.eng_addr = 15'(i);
      #1;
      if (bus.eng_gnt) begin e_cnt++; e_at = i; end
      if (bus.disp_gnt) d_cnt++;
      if (bus.disp_gnt === bus.eng_gnt) bad++;
      if (bus.eng_rvalid) begin erv_n++; erd = bus.eng_rdata; end
    end
    chk("starve_eng_cnt", e_cnt, 1);
    chk("starve_eng_cycle", e_at, 65);
    chk("starve_disp_cnt", d_cnt, 69);
    chk("starve_one_grant", bad, 0);
    chk("starve_eng_rvalid", erv_n, 1);
    chk("starve_eng_rdata", erd, f(16'h0041));
    @(negedge clk); bus.disp_req = 1'b0; bus.eng_req = 1'b0;
    repeat (4) @(negedge clk);
    // engine write goes to the back bank
    bus.eng_req = 1'b1; bus.eng_we = 1'b1; bus.eng_addr = 15'h0100; bus.eng_wdata = 20'hABCDE; #1;
    chk("wr_gnt", bus.eng_gnt, 1);
    @(negedge clk); bus.eng_req = 1'b0; #1;
    chk("wr_mem", {bus.mem_we, bus.mem_addr}, {1'b1, 16'h8100});
    chk("wr_wdata", bus.mem_wdata, 20'hABCDE);
    @(negedge clk); #1;
    chk("wr_we_pulse", {bus.mem_we, bus.mem_addr}, {1'b0, 16'h8100});
    @(negedge clk); @(negedge clk); #1;
    chk("wr_no_rvalid", {bus.disp_rvalid, bus.eng_rvalid}, 0);
    // vsync without eng_done repeats the frame
    @(negedge clk); bus.vsync = 1'b1;
    @(negedge clk); bus.vsync = 1'b0;
    gs_cnt = 0;
    repeat (4) begin @(negedge clk); #1; if (bus.gen_start) gs_cnt++; end
    chk("repeat_no_gen_start", gs_cnt, 0);
    chk("repeat_bank", bus.front_bank, 0);
`ifdef FB_ARB_PERF_EN
    chk("perf_frame_repeat", frame_repeat_cnt, 1);
    chk("perf_eng_stall", eng_stall_cnt, 69);
`endif
    // eng_done, vsync ten cycles later with two display reads in flight
    @(negedge clk); bus.eng_done = 1'b1; #1;
    bad = 0;
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      bus.eng_done = (j == 3); bus.eng_req = 1'b1; bus.eng_we = 1'b1; bus.eng_addr = 15'h0123;
      bus.eng_wdata = 20'h12345; bus.disp_req = (j == 9); bus.disp_addr = 15'h0021;
      #1;
      if (bus.eng_gnt) bad++;
    end
    @(negedge clk); bus.eng_done = 1'b0; bus.vsync = 1'b1; bus.disp_addr = 15'h0020; #1;
    chk("swap_vs_disp_gnt", bus.disp_gnt, 1);
    if (bus.eng_gnt) bad++;
    last_rv = 0; gs_cnt = 0; gs_at = 0; fb_at = 0; rd2 = '0; rd3 = '0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk); bus.vsync = 1'b0; bus.disp_req = 1'b0; #1;
      if (bus.disp_rvalid) begin
        last_rv = k;
        if (k == 2) rd2 = bus.disp_rdata;
        if (k == 3) rd3 = bus.disp_rdata;
      end
      if (bus.gen_start) begin gs_cnt++; gs_at = k; end
      if (bus.front_bank && fb_at == 0) fb_at = k;
      if (bus.eng_gnt) bad++;
    end
    chk("swap_eng_blocked", bad, 0);
    chk("swap_last_rvalid", last_rv, 3);
    chk("swap_rdata", {rd2, rd3}, {f(16'h0021), f(16'h0020)});
    chk("swap_bank_at", fb_at, 5);
    chk("swap_gen_start", {gs_cnt[7:0], gs_at[7:0]}, {8'd1, 8'd5});
    @(negedge clk); #1;
    chk("swap_gen_start_width", bus.gen_start, 0);
    chk("swap_eng_resume", bus.eng_gnt, 1);
    @(negedge clk); bus.eng_req = 1'b0; #1;
    chk("swap_write_new_back", {bus.mem_we, bus.mem_addr}, {1'b1, 16'h0123});
    // eng_done and vsync together: swap waits for the next vsync
    @(negedge clk); bus.eng_done = 1'b1; bus.vsync = 1'b1;
    @(negedge clk); bus.eng_done = 1'b0; bus.vsync = 1'b0; bus.eng_req = 1'b1; bus.eng_we = 1'b0; #1;
    chk("same_cycle_wait_vs", bus.eng_gnt, 0);
    @(negedge clk); bus.eng_req = 1'b0; bus.vsync = 1'b1; #1;
    chk("same_cycle_no_swap", {bus.gen_start, bus.front_bank}, 2'b01);
    @(negedge clk); bus.vsync = 1'b0; #1;
    chk("min_drain", {bus.gen_start, bus.front_bank}, 2'b01);
    @(negedge clk); #1;
    chk("min_swap", {bus.gen_start, bus.front_bank}, 2'b10);
    @(negedge clk); #1;
    chk("min_swap_end", bus.gen_start, 0);
    // reset one cycle after a read grant
    @(negedge clk); bus.disp_req = 1'b1; bus.disp_addr = 15'h0030; #1;
    chk("rst_read_gnt", bus.disp_gnt, 1);
    @(negedge clk); bus.eng_req = 1'b1; reset = 1'b1; #1;
    chk("rst_ctrl", {bus.disp_gnt, bus.eng_gnt, bus.disp_rvalid, bus.eng_rvalid, bus.mem_we, bus.gen_start, bus.front_bank}, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_rdata", {bus.disp_rdata, bus.eng_rdata}, 0);
    @(negedge clk); #1;
    chk("rst_hold_rvalid", {bus.disp_rvalid, bus.eng_rvalid}, 0);
    @(negedge clk); reset = 1'b0; bus.disp_req = 1'b0; bus.eng_req = 1'b0;
    rv_n = 0;
    repeat (6) begin @(negedge clk); #1; if (bus.disp_rvalid || bus.eng_rvalid) rv_n++; end
    chk("rst_discard", rv_n, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
